// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with a data-memory handshake.
//   Captures the EX outputs into an input register. Issues aligned loads and
//   stores on the dm_* port. Waits on dm_ready, giving up after TIMEOUT wait
//   cycles. Extracts and extends load data, and presents the WB/forwarding
//   bundle.
// Ports:
//   clk, rst            clock, async active-high reset
//   *_i                 EX-stage instruction bundle
//   dm_req/we/be/addr/wdata, dm_rdata, dm_ready   data-memory handshake
//   stall_o             freeze upstream stages and this stage's input register
//   addr_err_o          one-cycle pulse on misaligned or timed-out access
//   regWr/regAddr/regData, inst_debug_o/pc_debug_o  WB bundle
//   memu_isLoad         registered load flag for the hazard unit

// One byte lane of the store path: lane enable and the byte steered into it.
module mem_stage_lane #(
    parameter int LANE = 0
) (
    input  logic       is_byte,
    input  logic       is_half,
    input  logic [1:0] addr,
    input  logic [7:0] b_byte,   // sdata[7:0]
    input  logic [7:0] b_half,   // byte of sdata[15:0] that lands in this lane
    input  logic [7:0] b_word,   // sdata[8*LANE+:8]
    output logic       be,
    output logic [7:0] wdata
);
    localparam logic [1:0] L = 2'(LANE);

    always_comb begin
        if (is_byte) begin
            be    = (addr == L);
            wdata = b_byte;
        end else if (is_half) begin
            be    = (addr[1] == L[1]);
            wdata = b_half;
        end else begin
            be    = 1'b1;
            wdata = b_word;
        end
    end
endmodule

module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        regWr_i,
    input  logic [4:0]  regAddr_i,
    input  logic [31:0] aluResult_i,
    input  logic        memRd_i,
    input  logic        memWr_i,
    input  logic [2:0]  memOp_i,
    input  logic [31:0] storeData_i,
    input  logic [31:0] inst_debug_i,
    input  logic [31:0] pc_debug_i,
    output logic        dm_req,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ready,
    output logic        stall_o,
    output logic        addr_err_o,
    output logic        regWr,
    output logic [4:0]  regAddr,
    output logic [31:0] regData,
    output logic [31:0] inst_debug_o,
    output logic [31:0] pc_debug_o,
    output logic        memu_isLoad
);
    localparam int NUM_LANES = 4;
    localparam int CW        = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic        regWr;
        logic [4:0]  regAddr;
        logic [31:0] alu;
        logic        memRd;
        logic        memWr;
        logic [2:0]  memOp;
        logic [31:0] sdata;
        logic [31:0] inst;
        logic [31:0] pc;
    } ex_mem_t;

    typedef enum logic { S_RUN, S_WAIT } state_t;

    ex_mem_t r, r_nxt;
    state_t  state;
    logic [CW-1:0] cnt;

    logic is_byte, is_half, is_uns, is_mem, misalign, access, timeout, pending;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [NUM_LANES-1:0]      lane_be;
    logic [NUM_LANES-1:0][7:0] lane_wd;

    assign r_nxt = '{regWr: regWr_i, regAddr: regAddr_i, alu: aluResult_i,
                     memRd: memRd_i, memWr: memWr_i, memOp: memOp_i,
                     sdata: storeData_i, inst: inst_debug_i, pc: pc_debug_i};

    // Input register: frozen while the access is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r <= '0;
        else if (!stall_o) r <= r_nxt;
    end

    // Size decode; unlisted encodings fall through to word.
    assign is_byte = (r.memOp == 3'b000) || (r.memOp == 3'b100);
    assign is_half = (r.memOp == 3'b001) || (r.memOp == 3'b101);
    assign is_uns  = (r.memOp == 3'b100) || (r.memOp == 3'b101);

    assign is_mem   = r.memRd | r.memWr;
    assign misalign = is_mem & ((is_half & r.alu[0]) |
                                (!is_byte & !is_half & (|r.alu[1:0])));
    assign access   = is_mem & !misalign;
    assign timeout  = (state == S_WAIT) && (cnt == CW'(TIMEOUT));

    // In WAIT the held instruction is by construction an aligned access, so
    // the request stays up until completion or the timeout abort cycle.
    assign pending  = (state == S_RUN) ? access : !timeout;

    // FSM + wait counter. The counter counts WAIT cycles without dm_ready;
    // the cycle after it reaches TIMEOUT is the abort cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    cnt <= '0;
                    if (access && !dm_ready) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (timeout || dm_ready) begin
                        state <= S_RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Store lanes
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        mem_stage_lane #(.LANE(g)) u_lane (
            .is_byte (is_byte),
            .is_half (is_half),
            .addr    (r.alu[1:0]),
            .b_byte  (r.sdata[7:0]),
            .b_half  (r.sdata[8*(g%2) +: 8]),
            .b_word  (r.sdata[8*g +: 8]),
            .be      (lane_be[g]),
            .wdata   (lane_wd[g])
        );
    end

    assign dm_req   = pending;
    assign dm_we    = r.memWr;
    assign dm_be    = lane_be;
    assign dm_addr  = {r.alu[31:2], 2'b00};
    assign dm_wdata = lane_wd;

    assign stall_o    = pending & !dm_ready;
    assign addr_err_o = misalign | timeout;

    // Load data extraction
    assign ld_byte = dm_rdata[{r.alu[1:0], 3'b000} +: 8];
    assign ld_half = dm_rdata[{r.alu[1], 4'b0000} +: 16];

    always_comb begin
        regData = r.alu;
        if (r.memRd) begin
            if (is_byte)      regData = {{24{ld_byte[7] & !is_uns}}, ld_byte};
            else if (is_half) regData = {{16{ld_half[15] & !is_uns}}, ld_half};
            else              regData = dm_rdata;
        end
    end

    assign regWr        = r.regWr & !stall_o & !misalign & !timeout;
    assign regAddr      = r.regAddr;
    assign inst_debug_o = r.inst;
    assign pc_debug_o   = r.pc;
    assign memu_isLoad  = r.memRd;
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 16: dm_ready wait-cycle limit before an access aborts.
REQ-002 clk  in  1  sole clock; all state SHALL update on posedge clk.
REQ-003 rst  in  1  reset; asynchronous, active-high.
REQ-004 regWr_i  in  1  EX: instruction writes a register.
REQ-005 regAddr_i  in  5  EX: destination register.
REQ-006 aluResult_i  in  32  EX: ALU result / effective address.
REQ-007 memRd_i  in  1  EX: load.
REQ-008 memWr_i  in  1  EX: store.
REQ-009 memOp_i  in  3  size/sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu; others SHALL act as 010.
REQ-010 storeData_i  in  32  EX: store source (rt).
REQ-011 inst_debug_i  in  32  EX: debug instruction.
REQ-012 pc_debug_i  in  32  EX: debug PC.
REQ-013 dm_req  out  1  data-memory request.
REQ-014 dm_we  out  1  1 = store, 0 = load.
REQ-015 dm_be  out  4  byte enables, little-endian lanes.
REQ-016 dm_addr  out  32  word address {addr[31:2],2'b00}.
REQ-017 dm_wdata  out  32  lane-replicated store data.
REQ-018 dm_rdata  in  32  load data, valid when dm_ready=1.
REQ-019 dm_ready  in  1  access completes this cycle.
REQ-020 stall_o  out  1  freeze PC/IF/ID/EX and this stage's input register.
REQ-021 addr_err_o  out  1  one-cycle pulse: misaligned or timed-out access.
REQ-022 regWr  out  1  to WB; also EX forwarding source.
REQ-023 regAddr  out  5  to WB / forwarding.
REQ-024 regData  out  32  to WB / forwarding.
REQ-025 inst_debug_o  out  32  to WB.
REQ-026 pc_debug_o  out  32  to WB.
REQ-027 memu_isLoad  out  1  registered memRd; hazard unit inserts load-use bubble.

Function
REQ-028 Input register SHALL capture all *_i on posedge clk when stall_o=0 and hold when stall_o=1.
REQ-029 FSM states RUN, WAIT; RUN->WAIT when access issued and dm_ready=0; WAIT->RUN on dm_ready=1 or timeout.
REQ-030 Access = registered memRd|memWr with aligned address; dm_req SHALL be 1 in RUN for an access and in every WAIT cycle, with dm_addr/dm_we/dm_be/dm_wdata held stable.
REQ-031 Alignment: half needs addr[0]=0, word needs addr[1:0]=00; misaligned SHALL give dm_req=0, regWr=0, addr_err_o=1 for that cycle, no stall.
REQ-032 stall_o SHALL equal access pending AND dm_ready=0 (combinational); regWr SHALL be 0 while stall_o=1.
REQ-033 Completion cycle: regWr = registered regWr_i, debug outputs pass through; non-access instructions complete in one cycle.
REQ-034 Load data: byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16], sign- or zero-extended per memOp; non-load regData = aluResult.
REQ-035 Store: sb dm_be=1<<addr[1:0], wdata={4{byte}}; sh dm_be=0011/1100 by addr[1], wdata={2{half}}; sw dm_be=1111.
REQ-036 WAIT counter SHALL increment each WAIT cycle with dm_ready=0; on reaching TIMEOUT, access SHALL abort: dm_req=0, stall_o=0, regWr=0, addr_err_o=1, ->RUN, counter cleared.
REQ-037 dm_ready while no access pending SHALL be ignored.

Reset
REQ-038 rst=1 SHALL immediately force dm_req, stall_o, regWr, addr_err_o, memu_isLoad to 0, zero all registers and counter, state RUN; a WAIT access in progress is abandoned.

Verification
REQ-039 lw addr 0x100, dm_ready=1 same cycle, rdata=0xDEADBEEF -> regData=0xDEADBEEF, regWr=1, stall_o=0, dm_be=1111.
REQ-040 lb addr 0x103, rdata=0x80xxxxxx -> regData=0xFFFFFF80; lbu -> 0x00000080.
REQ-041 sh addr 0x202, storeData=0x1234ABCD -> dm_be=1100, dm_wdata=0xABCDABCD, dm_we=1, regWr=0.
REQ-042 lw with dm_ready low 3 cycles -> stall_o=1 for 3 cycles, inputs held, regWr=0 then 1 on ready cycle.
REQ-043 lh addr 0x101 -> dm_req=0, addr_err_o=1 one cycle; dm_ready never -> abort after 16 WAIT cycles with addr_err_o pulse.
REQ-044 rst asserted in WAIT -> dm_req, stall_o drop same cycle; after release, ALU instruction completes normally.
